// File: rtl/invaes_ctrl_pkg.sv
// Shared types and constants for the inverse-AES round controller.
package invaes_ctrl_pkg;

    localparam int unsigned NROUNDS = 10;
    localparam int unsigned RND_W   = 4;

    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NROUNDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EXPAND = 3'd2,
        S_INIT   = 3'd3,
        S_ROUNDS = 3'd4,
        S_FINAL  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    // Registered control strobes driven to the datapath and key store.
    typedef struct packed {
        logic key_ld;
        logic data_ld;
        logic kexp_en;
        logic kmem_we;
        logic addkey_only;
        logic round_en;
        logic final_rnd;
        logic out_we;
        logic done;
    } strobes_t;

endpackage

// File: rtl/invaes_ctrl_sync_edge.sv
// Two-flop synchronizer for the SPI load strobe plus falling-edge detector.
module invaes_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one extra flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/invaes_ctrl.sv
// Sequencer for the inverse-AES core: key load, forward key expansion into
// the key store, then initial AddRoundKey and inverse rounds 9..0.
module invaes_ctrl
    import invaes_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    output logic             done,
    output logic [RND_W-1:0] rnd,
    output logic             key_ld,
    output logic             data_ld,
    output logic             kexp_en,
    output logic             kmem_we,
    output logic             addkey_only,
    output logic             round_en,
    output logic             final_rnd,
    output logic             out_we
);

    logic ld_s;
    logic start;

    state_e           state_q;
    logic [RND_W-1:0] rnd_q;
    strobes_t         st_q;

    invaes_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (load),
        .sync_o  (ld_s),
        .fall_o  (start)
    );

    // Sequencer: state, round counter and strobes for the next cycle, all
    // registered. Defaults return to IDLE, which also covers abort and any
    // out-of-range count or state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
            if (rnd_q <= RND_LAST && !(ld_s && state_q != S_IDLE)) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q      <= S_LOAD;
                            st_q.key_ld  <= 1'b1;
                            st_q.data_ld <= 1'b1;
                            st_q.kmem_we <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state_q      <= S_EXPAND;
                        rnd_q        <= RND_W'(1);
                        st_q.kexp_en <= 1'b1;
                        st_q.kmem_we <= 1'b1;
                    end
                    S_EXPAND: begin
                        if (rnd_q == RND_LAST) begin
                            state_q          <= S_INIT;
                            rnd_q            <= RND_LAST;
                            st_q.addkey_only <= 1'b1;
                        end else begin
                            state_q      <= S_EXPAND;
                            rnd_q        <= rnd_q + RND_W'(1);
                            st_q.kexp_en <= 1'b1;
                            st_q.kmem_we <= 1'b1;
                        end
                    end
                    S_INIT: begin
                        state_q       <= S_ROUNDS;
                        rnd_q         <= RND_LAST - RND_W'(1);
                        st_q.round_en <= 1'b1;
                    end
                    S_ROUNDS: begin
                        st_q.round_en <= 1'b1;
                        if (rnd_q == RND_W'(1)) begin
                            state_q        <= S_FINAL;
                            rnd_q          <= '0;
                            st_q.final_rnd <= 1'b1;
                            st_q.out_we    <= 1'b1;
                        end else begin
                            state_q <= S_ROUNDS;
                            rnd_q   <= rnd_q - RND_W'(1);
                        end
                    end
                    S_FINAL, S_DONE: begin
                        state_q   <= S_DONE;
                        st_q.done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rnd         = rnd_q;
    assign done        = st_q.done;
    assign key_ld      = st_q.key_ld;
    assign data_ld     = st_q.data_ld;
    assign kexp_en     = st_q.kexp_en;
    assign kmem_we     = st_q.kmem_we;
    assign addkey_only = st_q.addkey_only;
    assign round_en    = st_q.round_en;
    assign final_rnd   = st_q.final_rnd;
    assign out_we      = st_q.out_we;

endmodule

// File: tb/tb_invaes_ctrl.sv
// Directed bench for invaes_ctrl with a strobe-sequence scoreboard.
module tb_invaes_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       done;
    logic [3:0] rnd;
    logic       key_ld, data_ld, kexp_en, kmem_we;
    logic       addkey_only, round_en, final_rnd, out_we;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [7:0]  strb;
        logic [3:0]  rnd;
        logic        drise;
        int unsigned offs;
    } ev_t;

    ev_t exp_q[$];

    invaes_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .done        (done),
        .rnd         (rnd),
        .key_ld      (key_ld),
        .data_ld     (data_ld),
        .kexp_en     (kexp_en),
        .kmem_we     (kmem_we),
        .addkey_only (addkey_only),
        .round_en    (round_en),
        .final_rnd   (final_rnd),
        .out_we      (out_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected strobe vector {key_ld,data_ld,kexp_en,kmem_we,addkey_only,round_en,final_rnd,out_we}
    function automatic ev_t exp_at(input int unsigned c);
        ev_t e;
        e.drise = 1'b0;
        e.offs  = c;
        if (c == 0) begin
            e.strb = 8'b1101_0000; e.rnd = 4'd0;
        end else if (c <= 10) begin
            e.strb = 8'b0011_0000; e.rnd = 4'(c);
        end else if (c == 11) begin
            e.strb = 8'b0000_1000; e.rnd = 4'd10;
        end else if (c <= 20) begin
            e.strb = 8'b0000_0100; e.rnd = 4'(21 - c);
        end else begin
            e.strb = 8'b0000_0111; e.rnd = 4'd0;
        end
        return e;
    endfunction

    task automatic push_range(input int unsigned last);
        for (int unsigned c = 0; c <= last; c++) exp_q.push_back(exp_at(c));
    endtask

    task automatic push_run();
        ev_t e;
        push_range(21);
        e.strb = 8'h00; e.rnd = 4'd0; e.drise = 1'b1; e.offs = 22;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_level(input string tag, input logic lvl, input int unsigned bound);
        for (int unsigned i = 0; i < bound; i++) begin
            if (done === lvl) break;
            tick();
        end
        chk(tag, {31'd0, done}, {31'd0, lvl});
    endtask

    // Monitor: exclusivity every cycle; every strobe cycle or done rise is
    // matched in order against the scoreboard, with its offset from LOAD.
    int unsigned cyc = 0;
    int unsigned t0  = 0;
    logic        done_prev = 1'b0;

    always @(negedge clk) begin
        logic [7:0] strb;
        logic       drise;
        int unsigned n1hot;
        ev_t        e;
        strb  = {key_ld, data_ld, kexp_en, kmem_we, addkey_only, round_en, final_rnd, out_we};
        cyc++;
        if (key_ld) t0 = cyc;
        drise     = done && !done_prev;
        done_prev = done;
        n1hot = 32'(key_ld) + 32'(kexp_en) + 32'(addkey_only) + 32'(round_en);
        chk("exclusive", {31'd0, n1hot > 1}, 32'd0);
        chk("rnd_range", {31'd0, rnd > 4'd10}, 32'd0);
        if (strb != 8'h00 || drise) begin
            if (exp_q.size() == 0) begin
                chk("unexpected", {23'd0, drise, strb}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("seq", {19'd0, drise, strb, rnd}, {19'd0, e.drise, e.strb, e.rnd});
                chk("seq_cycle", cyc - t0, e.offs);
            end
        end
    end

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        // Reset state
        repeat (3) tick();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rnd", {28'd0, rnd}, 32'd0);
        reset = 1'b0;
        repeat (50) tick();
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_rnd", {28'd0, rnd}, 32'd0);

        // Normal run
        load = 1'b1;
        repeat (20) tick();
        push_run();
        load = 1'b0;
        repeat (3) tick();
        chk("load_latency", {31'd0, key_ld}, 32'd1);
        wait_level("run1_done", 1'b1, 40);
        repeat (5) tick();
        chk("done_held", {31'd0, done}, 32'd1);
        chk("run1_q", exp_q.size(), 32'd0);

        // Release done, then repeat
        load = 1'b1;
        wait_level("done_clear", 1'b0, 4);
        repeat (5) tick();
        push_run();
        load = 1'b0;
        wait_level("run2_done", 1'b1, 40);
        tick();
        chk("run2_q", exp_q.size(), 32'd0);

        // Abort during EXPAND at rnd=5
        load = 1'b1;
        repeat (5) tick();
        push_range(7);
        load = 1'b0;
        repeat (3) tick();
        repeat (5) tick();
        chk("abort_at_rnd", {28'd0, rnd}, 32'd5);
        chk("abort_at_kexp", {31'd0, kexp_en}, 32'd1);
        load = 1'b1;
        repeat (3) tick();
        chk("abort_strobes", {24'd0, key_ld, data_ld, kexp_en, kmem_we, addkey_only, round_en, final_rnd, out_we}, 32'd0);
        chk("abort_rnd", {28'd0, rnd}, 32'd0);
        repeat (30) tick();
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", exp_q.size(), 32'd0);

        // Reset during ROUNDS at rnd=4
        push_range(17);
        load = 1'b0;
        repeat (3) tick();
        repeat (17) tick();
        chk("rst_at_rnd", {28'd0, rnd}, 32'd4);
        chk("rst_at_round_en", {31'd0, round_en}, 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_rnd", {28'd0, rnd}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_round_en", {31'd0, round_en}, 32'd0);
        reset = 1'b0;
        repeat (30) tick();
        chk("post_rst_idle", {31'd0, done}, 32'd0);
        chk("post_rst_q", exp_q.size(), 32'd0);
        load = 1'b1;
        repeat (5) tick();
        push_run();
        load = 1'b0;
        wait_level("run3_done", 1'b1, 40);
        tick();

        // Glitch missing every clock edge: no effect
        load = 1'b1;
        #2;
        load = 1'b0;
        repeat (30) tick();
        chk("short_glitch_done", {31'd0, done}, 32'd1);

        // Glitch straddling one rising edge: exactly one run
        push_run();
        #2;
        load = 1'b1;
        #4;
        load = 1'b0;
        wait_level("glitch_done_clear", 1'b0, 6);
        wait_level("glitch_run_done", 1'b1, 40);
        repeat (30) tick();
        chk("glitch_done_held", {31'd0, done}, 32'd1);
        chk("final_q", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
